// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the fetch PC generator.
//   pc_src_t     : execute-stage PC source select encoding
//   INSTR_BYTES  : bytes per instruction (fixed 32-bit ISA)
//   align_pc()   : clears the two low bits of a target address
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'b00,
    PC_BRJAL = 2'b01,
    PC_JALR  = 2'b10,
    PC_SEQ_B = 2'b11
  } pc_src_t;

  // Every loaded PC is word aligned; low bits are dropped, never faulted.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack -- circular return address stack.
//   clk, rst     : clock, synchronous active-high reset (empties the stack)
//   push_i       : push push_pc_i as new top
//   pop_i        : remove top (ignored when empty)
//   push_pc_i    : return address to push
//   top_o        : current top, 0 when empty
//   valid_o      : stack non-empty
// Push when full overwrites the oldest entry: the top pointer simply wraps
// onto it while the count saturates. Push+pop together replaces the top.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_pc_i,
  output logic [WIDTH-1:0] top_o,
  output logic             valid_o
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]                   tp_q, tp_d;
  logic [PW:0]                     cnt_q, cnt_d;
  logic                            wr_en;
  logic [PW-1:0]                   wr_idx;
  logic                            empty;

  assign empty = (cnt_q == '0);

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    if (push_i && pop_i && !empty) begin
      // replace top in place, depth unchanged
      wr_en  = 1'b1;
      wr_idx = tp_q;
    end else if (push_i) begin
      tp_d   = tp_q + PW'(1);
      wr_en  = 1'b1;
      wr_idx = tp_q + PW'(1);
      if (cnt_q != (PW+1)'(RAS_DEPTH)) cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop_i && !empty) begin
      tp_d  = tp_q - PW'(1);
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through a valid count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_pc_i;
  end

  assign valid_o = !empty;
  assign top_o   = empty ? '0 : mem_q[tp_q];

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen -- fetch-group PC generator with optional return address stack.
//   clk, rst          : clock, synchronous active-high reset
//   en                : advance fetch (0 = stall, base holds)
//   mispredict_i/_pc_i: highest-priority redirect, ignores en
//   predict_i/_pc_i   : predictor redirect, ignores en
//   pc_src_e          : 00/11 sequential, 01 branch/jal, 10 jalr
//   pc_target_e       : branch/jal target
//   alu_result_e      : jalr target
//   ras_push_i/_pop_i : call push / return pop, ras_push_pc_i pushed value
//   pc_o[k]           : base + 4k per lane
//   pc_plus4_o[k]     : pc_o[k] + 4
//   ras_top_o/valid_o : RAS top and non-empty flag (0 without the RAS)
// Build option: define FETCH_PC_GEN_RAS_EN to include the return address stack.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               FETCH_WIDTH = 2,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               RAS_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                mispredict_i,
  input  logic [WIDTH-1:0]                    mispredict_pc_i,
  input  logic                                predict_i,
  input  logic [WIDTH-1:0]                    predict_pc_i,
  input  logic [1:0]                          pc_src_e,
  input  logic [WIDTH-1:0]                    pc_target_e,
  input  logic [WIDTH-1:0]                    alu_result_e,
  input  logic                                ras_push_i,
  input  logic                                ras_pop_i,
  input  logic [WIDTH-1:0]                    ras_push_pc_i,
  output logic [FETCH_WIDTH-1:0][WIDTH-1:0]   pc_o,
  output logic [FETCH_WIDTH-1:0][WIDTH-1:0]   pc_plus4_o,
  output logic [WIDTH-1:0]                    ras_top_o,
  output logic                                ras_valid_o
);

  localparam logic [WIDTH-1:0] GROUP_STEP = WIDTH'(INSTR_BYTES * FETCH_WIDTH);

  logic [WIDTH-1:0] base_q, base_d;

  function automatic logic [WIDTH-1:0] aln(input logic [WIDTH-1:0] pc);
    return {pc[WIDTH-1:2], 2'b00};
  endfunction

  always_comb begin
    base_d = base_q;
    if (mispredict_i) begin
      base_d = aln(mispredict_pc_i);
    end else if (predict_i) begin
      base_d = aln(predict_pc_i);
    end else if (en) begin
      case (pc_src_t'(pc_src_e))
        PC_BRJAL: base_d = aln(pc_target_e);
        PC_JALR:  base_d = aln(alu_result_e);
        default:  base_d = base_q + GROUP_STEP; // 00 and 11 are sequential
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) base_q <= aln(RESET_PC);
    else     base_q <= base_d;
  end

  // Lane outputs are combinational off the base register; all sums wrap.
  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
    assign pc_o[k]       = base_q + WIDTH'(INSTR_BYTES * k);
    assign pc_plus4_o[k] = base_q + WIDTH'(INSTR_BYTES * (k + 1));
  end

`ifdef FETCH_PC_GEN_RAS_EN
  // Mispredict deliberately has no path into the stack.
  ras_stack #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push_i   (ras_push_i),
    .pop_i    (ras_pop_i),
    .push_pc_i(ras_push_pc_i),
    .top_o    (ras_top_o),
    .valid_o  (ras_valid_o)
  );
  logic unused_bits;
  assign unused_bits = ^{alu_result_e[1:0]};
`else
  assign ras_top_o   = '0;
  assign ras_valid_o = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{ras_push_i, ras_pop_i, ras_push_pc_i, alu_result_e[1:0]};
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              mispredict_i = 1'b0;
  logic [31:0]       mispredict_pc_i = '0;
  logic              predict_i = 1'b0;
  logic [31:0]       predict_pc_i = '0;
  logic [1:0]        pc_src_e = 2'b00;
  logic [31:0]       pc_target_e = '0;
  logic [31:0]       alu_result_e = '0;
  logic              ras_push_i = 1'b0;
  logic              ras_pop_i = 1'b0;
  logic [31:0]       ras_push_pc_i = '0;
  logic [1:0][31:0]  pc_o;
  logic [1:0][31:0]  pc_plus4_o;
  logic [31:0]       ras_top_o;
  logic              ras_valid_o;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_pc_gen #(
    .WIDTH(32), .FETCH_WIDTH(2), .RESET_PC(32'h100), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .mispredict_i(mispredict_i), .mispredict_pc_i(mispredict_pc_i),
    .predict_i(predict_i), .predict_pc_i(predict_pc_i),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .alu_result_e(alu_result_e),
    .ras_push_i(ras_push_i), .ras_pop_i(ras_pop_i), .ras_push_pc_i(ras_push_pc_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .ras_top_o(ras_top_o), .ras_valid_o(ras_valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // all four lane outputs against a hand-computed base
  task automatic chk_pc(input string tag, input logic [31:0] b);
    chk({tag, ".pc0"}, pc_o[0], b);
    chk({tag, ".pc1"}, pc_o[1], b + 32'd4);
    chk({tag, ".p40"}, pc_plus4_o[0], b + 32'd4);
    chk({tag, ".p41"}, pc_plus4_o[1], b + 32'd8);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; mispredict_i = 0; predict_i = 0; pc_src_e = 2'b00;
    ras_push_i = 0; ras_pop_i = 0;
  endtask

  task automatic ras(input logic push, input logic pop, input logic [31:0] v);
    ras_push_i = push; ras_pop_i = pop; ras_push_pc_i = v;
    tick();
    ras_push_i = 0; ras_pop_i = 0;
  endtask

  initial begin
    // reset
    tick(); tick();
    rst = 0;
    chk_pc("reset", 32'h100);
    chk("reset.rasv", {31'd0, ras_valid_o}, 32'd0);
    chk("reset.rast", ras_top_o, 32'd0);

    // get base to 0 via mispredict, then three sequential groups
    mispredict_i = 1; mispredict_pc_i = 32'h0; tick(); idle();
    chk_pc("mp0", 32'h0);
    en = 1; pc_src_e = 2'b00;
    tick(); chk_pc("seq1", 32'h8);
    tick(); chk_pc("seq2", 32'h10);
    tick(); chk_pc("seq3", 32'h18);
    en = 0; tick(); tick();
    chk_pc("stall", 32'h18);

    // priority: mispredict over predict over pc_src, with en=0
    mispredict_i = 1; mispredict_pc_i = 32'h200;
    predict_i = 1; predict_pc_i = 32'h300; pc_src_e = 2'b01; pc_target_e = 32'h500;
    tick(); idle();
    chk_pc("prio", 32'h200);

    // predict alone, en=0, low bits dropped
    predict_i = 1; predict_pc_i = 32'h303; tick(); idle();
    chk_pc("pred", 32'h300);

    // predict beats en/pc_src
    predict_i = 1; predict_pc_i = 32'h600; en = 1; pc_src_e = 2'b01; pc_target_e = 32'h700;
    tick(); idle();
    chk_pc("predovr", 32'h600);

    // branch target with misaligned low bits
    en = 1; pc_src_e = 2'b01; pc_target_e = 32'h403; tick(); idle();
    chk_pc("br", 32'h400);

    // pc_src 01 with en=0 must not move
    pc_src_e = 2'b01; pc_target_e = 32'h900; tick(); idle();
    chk_pc("brstall", 32'h400);

    // jalr
    en = 1; pc_src_e = 2'b10; alu_result_e = 32'h1237; tick(); idle();
    chk_pc("jalr", 32'h1234);

    // 11 is sequential
    en = 1; pc_src_e = 2'b11; tick(); idle();
    chk_pc("seq11", 32'h123C);

    // wrap at top of address space
    mispredict_i = 1; mispredict_pc_i = 32'hFFFF_FFFC; tick(); idle();
    chk_pc("wrapbase", 32'hFFFF_FFFC);
    en = 1; tick(); idle();
    chk_pc("wrap", 32'h4);

    // reset overrides a simultaneous mispredict
    rst = 1; mispredict_i = 1; mispredict_pc_i = 32'h800; tick();
    rst = 0; idle();
    chk_pc("rstovr", 32'h100);

`ifdef FETCH_PC_GEN_RAS_EN
    // 5 pushes into depth 4: oldest (0x10) overwritten
    for (int i = 1; i <= 5; i++) ras(1, 0, 32'(i * 16));
    chk("ras.v5", {31'd0, ras_valid_o}, 32'd1);
    chk("ras.t5", ras_top_o, 32'h50);
    ras(0, 1, 0); chk("ras.pop1", ras_top_o, 32'h40);
    ras(0, 1, 0); chk("ras.pop2", ras_top_o, 32'h30);
    ras(0, 1, 0); chk("ras.pop3", ras_top_o, 32'h20);
    ras(0, 1, 0);
    chk("ras.pop4v", {31'd0, ras_valid_o}, 32'd0);
    chk("ras.pop4t", ras_top_o, 32'd0);
    ras(0, 1, 0);
    chk("ras.pop5v", {31'd0, ras_valid_o}, 32'd0);
    // an ignored empty pop must leave the pointer alone
    ras(1, 0, 32'h77); chk("ras.afterempty", ras_top_o, 32'h77);
    ras(0, 1, 0);

    // push+pop when empty acts as push
    ras(1, 1, 32'h55);
    chk("ras.ppempty", ras_top_o, 32'h55);
    chk("ras.ppemptyv", {31'd0, ras_valid_o}, 32'd1);
    ras(0, 1, 0);

    // replace top: 0x10..0x40 then push+pop 0x99
    for (int i = 1; i <= 4; i++) ras(1, 0, 32'(i * 16));
    ras(1, 1, 32'h99);
    chk("ras.repl", ras_top_o, 32'h99);
    // mispredict must not disturb the stack
    mispredict_i = 1; mispredict_pc_i = 32'h40; tick(); idle();
    chk("ras.mp", ras_top_o, 32'h99);
    ras(0, 1, 0); chk("ras.repl1", ras_top_o, 32'h30);
    ras(0, 1, 0); chk("ras.repl2", ras_top_o, 32'h20);
    ras(0, 1, 0); chk("ras.repl3", ras_top_o, 32'h10);

    // reset mid-sequence empties it
    rst = 1; tick(); rst = 0;
    chk("ras.rstv", {31'd0, ras_valid_o}, 32'd0);
    chk("ras.rstt", ras_top_o, 32'd0);
`else
    // without the stack, push/pop have no visible effect
    ras(1, 0, 32'h44); ras(1, 0, 32'h48);
    chk("noras.v", {31'd0, ras_valid_o}, 32'd0);
    chk("noras.t", ras_top_o, 32'd0);
    ras(1, 1, 32'h4C);
    chk("noras.pp", ras_top_o, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/address width.
REQ-002 SHALL have parameter FETCH_WIDTH, default 2, instructions fetched per cycle (1..8).
REQ-003 SHALL have parameter RESET_PC, default 0, PC loaded on reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  1  fetch advance enable (low = stall).
REQ-008 SHALL have port mispredict_i  input  1  mispredict redirect request.
REQ-009 SHALL have port mispredict_pc_i  input  WIDTH  mispredict target.
REQ-010 SHALL have port predict_i  input  1  predictor redirect request.
REQ-011 SHALL have port predict_pc_i  input  WIDTH  predicted target.
REQ-012 SHALL have port pc_src_e  input  2  00 seq, 01 branch/jal, 10 jalr, 11 seq.
REQ-013 SHALL have port pc_target_e  input  WIDTH  branch/jal target.
REQ-014 SHALL have port alu_result_e  input  WIDTH  jalr target.
REQ-015 SHALL have port ras_push_i / ras_pop_i  input  1 each  call push / return pop.
REQ-016 SHALL have port ras_push_pc_i  input  WIDTH  return address to push.
REQ-017 SHALL have port pc_o  output  FETCH_WIDTH x WIDTH  per-lane fetch PC.
REQ-018 SHALL have port pc_plus4_o  output  FETCH_WIDTH x WIDTH  per-lane PC+4.
REQ-019 SHALL have ports ras_top_o  output  WIDTH, ras_valid_o  output  1  RAS top and non-empty flag.

Function
REQ-020 pc_o[k] SHALL equal base PC + 4*k; pc_plus4_o[k] = pc_o[k] + 4; all arithmetic modulo 2^WIDTH (wrap, no flag).
REQ-021 Next base priority SHALL be: mispredict_i > predict_i > (en and pc_src_e) > hold.
REQ-022 mispredict_i and predict_i SHALL load base regardless of en.
REQ-023 With en=1: pc_src_e 00/11 -> base + 4*FETCH_WIDTH; 01 -> pc_target_e; 10 -> {alu_result_e[WIDTH-1:2],2'b00}.
REQ-024 With en=0 and no redirect, base SHALL hold.
REQ-025 All loaded targets SHALL have bits [1:0] forced to 00.
REQ-026 Base update latency SHALL be one cycle (registered; outputs combinational from register).

Reset
REQ-027 On rst, base SHALL become RESET_PC (low 2 bits forced 00), so pc_o[k] = RESET_PC + 4k; rst overrides all other inputs.
REQ-028 On rst (with RAS_EN), RAS SHALL be emptied: ras_valid_o=0, ras_top_o=0.

Configuration
REQ-029 Macro FETCH_PC_GEN_RAS_EN SHALL compile in the return address stack.
REQ-030 With it: push writes ras_push_pc_i at top; pop removes top; ras_top_o/ras_valid_o reflect state after previous edge.
REQ-031 Push when full SHALL overwrite oldest entry (circular, count saturates at RAS_DEPTH).
REQ-032 Pop when empty SHALL be ignored (no pointer change).
REQ-033 Simultaneous push and pop SHALL replace top entry, count unchanged (push only if empty).
REQ-034 mispredict_i SHALL NOT alter the RAS.
REQ-035 Without macro: push/pop ignored, ras_valid_o=0, ras_top_o=0, no RAS storage.

Structure
REQ-036 Shared package fetch_pkg SHALL hold the pc_src encoding enum and INSTR_BYTES=4 constant.
REQ-037 RAS SHALL be sub-module ras_stack (WIDTH, RAS_DEPTH), instantiated only under the macro.

Verification
REQ-038 Reset with RESET_PC=0x100, FETCH_WIDTH=2 -> pc_o = {0x100,0x104}, pc_plus4_o = {0x104,0x108}.
REQ-039 en=1, pc_src_e=00 for 3 cycles from 0 -> base 0x8, 0x10, 0x18; en=0 -> holds 0x18.
REQ-040 mispredict_i=1 (0x200) with predict_i=1 (0x300), pc_src_e=01, en=0 -> base 0x200 next cycle.
REQ-041 en=1, pc_src_e=10, alu_result_e=0x1237 -> base 0x1234; base 0xFFFFFFFC seq -> wraps to 0x4.
REQ-042 RAS_EN, DEPTH=4: push 0x10..0x50 (5 pushes), 4 pops -> tops 0x50,0x40,0x30,0x20, then ras_valid_o=0; 5th pop no effect.
REQ-043 RAS_EN: push+pop same cycle on top 0x40 with push 0x99 -> top 0x99, count unchanged; rst mid-sequence -> ras_valid_o=0.
